div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider that the execute stage uses for DIV/DIVU.
- Execute stage raises start_i with operands and holds it until ready_o; it also holds its stall request during that time.
- Result returns packed as {remainder, quotient} for the HI/LO write path.
- Iterative restoring algorithm, one quotient bit per clock; ex/mem flush aborts via annul_i.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage (master) and the iterative divider (slave).
`timescale 1ns/1ps
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU: one quotient bit per clock, result packed as {remainder, quotient}.
`timescale 1ns/1ps
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   dividend_abs, divisor_abs;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_abs, rem_abs, quo_fix, rem_fix;

  always_comb begin
    a_neg        = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    b_neg        = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    dividend_abs = a_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    divisor_abs  = b_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

    // The partial remainder never reaches twice the divisor, so bit WIDTH of
    // the trial difference is a reliable sign bit.
    shifted = work_q << 1;
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_q};

    quo_abs = work_q[WIDTH-1:0];
    rem_abs = work_q[2*WIDTH-1:WIDTH];
    quo_fix = neg_quo_q ? (~quo_abs + 1'b1) : quo_abs;
    rem_fix = neg_rem_q ? (~rem_abs + 1'b1) : rem_abs;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = ready_q;
    result_d  = result_q;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            work_d    = {{(WIDTH+1){1'b0}}, dividend_abs};
            divisor_d = divisor_abs;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = S_ON;
          end
        end
      end

      S_BYZERO: begin
        work_d  = '0;
        state_d = S_END;
      end

      S_ON: begin
        if (bus.annul_i) begin
          cnt_d   = '0;
          state_d = S_FREE;
        end else if (cnt_q != CW'(WIDTH)) begin
          if (trial[WIDTH]) begin
            work_d = shifted;
          end else begin
            work_d = {trial, shifted[WIDTH-1:1], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Low 2*WIDTH bits of the work register now carry the signed-corrected result.
          work_d  = {1'b0, rem_fix, quo_fix};
          cnt_d   = '0;
          state_d = S_END;
        end
      end

      default: begin
        if (bus.start_i) begin
          ready_d  = 1'b1;
          result_d = work_q[2*WIDTH-1:0];
        end else begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = S_FREE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit: latency/arithmetic reference model plus directed literal cases.
`timescale 1ns/1ps
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  // Arithmetic reference: plain 64-bit signed/unsigned division with truncation toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: a sampled request completes after a fixed number of
  // edges (2 for a zero divisor, 34 otherwise) unless a flush lands first.
  bit          m_busy, m_ready, m_zero;
  int          m_cnt, m_lat;
  logic [63:0] m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  = 0;
      m_ready = 0;
      m_zero  = 0;
      m_cnt   = 0;
      m_lat   = 0;
      m_res   = 64'd0;
    end else if (!m_busy) begin
      if (bus.start_i && !bus.annul_i) begin
        m_busy = 1;
        m_cnt  = 0;
        m_zero = (bus.opdata2_i == 32'd0);
        m_lat  = m_zero ? 2 : 34;
        m_res  = ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
      end
    end else if (m_ready) begin
      if (!bus.start_i) begin
        m_busy  = 0;
        m_ready = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == m_lat) begin
        if (bus.start_i) m_ready = 1;
        else m_busy = 0;
      end else if (bus.annul_i && !m_zero && m_cnt < m_lat) begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("ready_o", {63'd0, bus.ready_o}, {63'd0, m_ready});
      check("result_o", bus.result_o, m_ready ? m_res : 64'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input string nm, input bit pin_model);
    int cyc;
    bit got;
    @(negedge clk);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.ready_o) got = 1;
      else begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
    end
    check({nm, " latency"}, 64'(cyc - 1), (b == 32'd0) ? 64'd2 : 64'd34);
    check({nm, " result"}, bus.result_o, exp);
    if (pin_model) check({nm, " model"}, m_res, exp);
    $display("div %s a=%h b=%h s=%0d -> %h after %0d cycles", nm, a, b, s, bus.result_o, cyc - 1);
    idle($urandom_range(0, 2));
    bus.start_i = 1'b0;
    @(negedge clk);
    check({nm, " drop ready"}, {63'd0, bus.ready_o}, 64'd0);
    check({nm, " drop result"}, bus.result_o, 64'd0);
  endtask

  task automatic run_annul(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int k, input string nm);
    bit seen;
    @(negedge clk);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    repeat (k) @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.ready_o;
    end
    check({nm, " no ready"}, {63'd0, seen}, 64'd0);
    $display("annul %s a=%h b=%h at iteration %0d, ready seen=%0d", nm, a, b, k, seen);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      3: return 32'(-int'($urandom_range(1, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    idle(2);
    check("reset ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset result", bus.result_o, 64'd0);
    rst = 1'b1;
    idle(2);

    run_div(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, "u100/7", 1);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s-7/2", 1);
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFF, 32'h3}, "s-7/-2", 1);
    run_div(32'hFFFF_FFFF, 32'd2, 1'b0, {32'h1, 32'h7FFF_FFFF}, "uFFFFFFFF/2", 1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, "sovf", 1);
    run_div(32'd1234, 32'd0, 1'b0, 64'd0, "div0", 1);

    run_annul(32'd100, 32'd7, 1'b0, 10, "a100/7");
    run_div(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, "u9/3", 1);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    idle(5);
    #2 rst = 1'b0;
    #1;
    check("rst on ready", {63'd0, bus.ready_o}, 64'd0);
    check("rst on result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Asynchronous reset while a result is being presented.
    @(negedge clk);
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    idle(36);
    check("end ready pre-rst", {63'd0, bus.ready_o}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst end ready", {63'd0, bus.ready_o}, 64'd0);
    check("rst end result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    run_div(32'd50, 32'd5, 1'b0, {32'h0, 32'hA}, "u50/5", 1);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      logic s;
      a = pick_op();
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : pick_op();
      s = 1'($urandom_range(0, 1));
      if (b != 32'd0 && $urandom_range(0, 4) == 0)
        run_annul(a, b, s, int'($urandom_range(1, 33)), "rand");
      else
        run_div(a, b, s, ref_div(a, b, s), "rand", 0);
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
